game_binary_entry: RTL and testbench

//  Reverse-direction companion to the binary quiz game. The block shows a random digit 1..7 on
//  the 7-seg display. The player then keys its 3-bit binary form, MSB first, with two buttons:
//  btn_zero enters 0, btn_one enters 1. Result shown: correct / error.

---
 rtl/game_pkg.sv | 27 ++
 rtl/btn_edge.sv | 29 ++
 rtl/random_digit.sv | 21 ++
 rtl/game_binary_entry.sv | 140 ++++++++++++++
 tb/tb_game_binary_entry.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the 7-seg game family.
//  - display codes driven into the shared game mux / 7-seg decoder
//  - FSM state type used by the games
//  - target mapping helper (3-bit random -> digit 1..7)
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHOW   = 3'd1,
    ST_BIT2   = 3'd2,
    ST_BIT1   = 3'd3,
    ST_BIT0   = 3'd4,
    ST_RESULT = 3'd5
  } game_state_t;

  localparam logic [3:0] DISP_CORRECT = 4'd10;
  localparam logic [3:0] DISP_ERROR   = 4'd11;
  localparam logic [3:0] DISP_OFF     = 4'd12;
  localparam logic [3:0] DISP_QUERY   = 4'd13;
  localparam logic [3:0] STREAK_MAX   = 4'd9;

  // Zero has no meaningful binary entry for the player, so it becomes 5.
  function automatic logic [2:0] map_target(input logic [2:0] r);
    return (r == 3'd0) ? 3'd5 : r;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Raw button conditioner: 2-flop synchronizer plus rising-edge detector.
//  clk     in  system clock
//  reset   in  asynchronous, active-high reset
//  i_btn   in  raw asynchronous level from the button
//  o_pulse out one-cycle pulse per rising edge of the synchronized level
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1, r_sync2, r_sync_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= i_btn;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign o_pulse = r_sync2 & ~r_sync_d;

endmodule

// File: rtl/random_digit.sv
// Free-running pseudo-random source shared by the games.
//  clk   in  system clock
//  reset in  asynchronous, active-high reset
//  rnd   out 4-bit pseudo-random value (never 0000)
module random_digit (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] rnd
);

  logic [3:0] r_lfsr;

  // x^4 + x^3 + 1, maximal length (15 states); seed must be non-zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lfsr <= 4'b0001;
    else       r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
  end

  assign rnd = r_lfsr;

endmodule

// File: rtl/game_binary_entry.sv
// Binary entry game: shows a digit 1..7, the player keys its 3-bit binary
// form MSB first (btn_zero = 0, btn_one = 1), then correct/error is shown.
//  clk      in  system clock
//  reset    in  asynchronous, active-high reset
//  btn_zero in  raw button, enters bit 0
//  btn_one  in  raw button, enters bit 1
//  value    out display code (0-9 digit, 10 correct, 11 error, 12 blank, 13 '?')
//  streak   out consecutive correct answers, saturating at 9
module game_binary_entry
  import game_pkg::*;
#(
  parameter int unsigned DELAY_TIME  = 10_000_000,
  parameter int unsigned TIMEOUT     = 50_000_000,
  parameter int unsigned COUNTER_LEN = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_zero,
  input  logic       btn_one,
  output logic [3:0] value,
  output logic [3:0] streak
);

  localparam logic [COUNTER_LEN-1:0] DLY_LAST = COUNTER_LEN'(DELAY_TIME - 1);
  localparam logic [COUNTER_LEN-1:0] TO_LAST  = COUNTER_LEN'(TIMEOUT - 1);
  localparam logic [COUNTER_LEN-1:0] CNT_ONE  = COUNTER_LEN'(1);

  logic       w_p0, w_p1, w_single, w_bit;
  logic [3:0] w_rnd;
  logic [2:0] w_shift;

  game_state_t            r_state,  w_state_nx;
  logic [COUNTER_LEN-1:0] r_cnt,    w_cnt_nx;
  logic [3:0]             r_value,  w_value_nx;
  logic [3:0]             r_streak, w_streak_nx;
  logic [2:0]             r_entry,  w_entry_nx;
  logic [2:0]             r_target, w_target_nx;

  btn_edge u_btn_zero (.clk(clk), .reset(reset), .i_btn(btn_zero), .o_pulse(w_p0));
  btn_edge u_btn_one  (.clk(clk), .reset(reset), .i_btn(btn_one),  .o_pulse(w_p1));
  random_digit u_rnd  (.clk(clk), .reset(reset), .rnd(w_rnd));

  // Simultaneous pulses are ambiguous and dropped everywhere.
  assign w_single = w_p0 ^ w_p1;
  assign w_bit    = w_p1;
  assign w_shift  = {r_entry[1:0], w_bit};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_value  <= DISP_OFF;
      r_streak <= 4'd0;
      r_entry  <= 3'd0;
      r_target <= 3'd0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_value  <= w_value_nx;
      r_streak <= w_streak_nx;
      r_entry  <= w_entry_nx;
      r_target <= w_target_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_value_nx  = r_value;
    w_streak_nx = r_streak;
    w_entry_nx  = r_entry;
    w_target_nx = r_target;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nx   = '0;
        w_value_nx = DISP_OFF;
        if (w_single) begin
          w_target_nx = map_target(w_rnd[2:0]);
          w_value_nx  = {1'b0, map_target(w_rnd[2:0])};
          w_entry_nx  = 3'd0;
          w_state_nx  = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (r_cnt == DLY_LAST) begin
          w_cnt_nx   = '0;
          w_value_nx = DISP_QUERY;
          w_state_nx = ST_BIT2;
        end else begin
          w_cnt_nx = r_cnt + CNT_ONE;
        end
      end
      ST_BIT2, ST_BIT1, ST_BIT0: begin
        if (w_single) begin
          w_entry_nx = w_shift;
          w_cnt_nx   = '0;
          if (r_state == ST_BIT0) begin
            // Judge the full word including the bit arriving this cycle.
            w_state_nx = ST_RESULT;
            if (w_shift == r_target) begin
              w_value_nx  = DISP_CORRECT;
              w_streak_nx = (r_streak >= STREAK_MAX) ? STREAK_MAX : r_streak + 4'd1;
            end else begin
              w_value_nx  = DISP_ERROR;
              w_streak_nx = 4'd0;
            end
          end else begin
            w_value_nx = {3'b000, w_bit};
            w_state_nx = (r_state == ST_BIT2) ? ST_BIT1 : ST_BIT0;
          end
        end else if (r_cnt == TO_LAST) begin
          w_cnt_nx    = '0;
          w_value_nx  = DISP_ERROR;
          w_streak_nx = 4'd0;
          w_state_nx  = ST_RESULT;
        end else begin
          w_cnt_nx = r_cnt + CNT_ONE;
        end
      end
      ST_RESULT: begin
        if (r_cnt == DLY_LAST) begin
          w_cnt_nx   = '0;
          w_value_nx = DISP_OFF;
          w_state_nx = ST_IDLE;
        end else begin
          w_cnt_nx = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_cnt_nx   = '0;
        w_value_nx = DISP_OFF;
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  assign value  = r_value;
  assign streak = r_streak;

endmodule

// File: tb/tb_game_binary_entry.sv
// Directed bench for game_binary_entry with DELAY_TIME=4, TIMEOUT=20.
// Press timing: a button raised at a negedge produces an FSM update on the
// third following posedge (two sync flops + edge register).
module tb_game_binary_entry;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_zero = 1'b0;
  logic       btn_one = 1'b0;
  logic [3:0] value;
  logic [3:0] streak;

  int n_chk = 0;
  int n_err = 0;
  int exp_streak = 0;
  logic [2:0] tgt;

  game_binary_entry #(.DELAY_TIME(4), .TIMEOUT(20), .COUNTER_LEN(26)) dut (
    .clk(clk), .reset(reset), .btn_zero(btn_zero), .btn_one(btn_one),
    .value(value), .streak(streak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic press(input logic z, input logic o);
    @(negedge clk);
    btn_zero = z;
    btn_one  = o;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_btn();
    @(negedge clk);
    btn_zero = 1'b0;
    btn_one  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Starts a round from IDLE, returns the displayed target, ends in BIT2.
  task automatic start_round(input logic use_one, output logic [2:0] t);
    press(~use_one, use_one);
    t = value[2:0];
    chk("show_range", {7'd0, (value >= 4'd1 && value <= 4'd7)}, 8'd1);
    release_btn();
    chk("show_hold", {4'd0, value}, {5'd0, t});
    @(posedge clk); #1;
    chk("bit2_query", {4'd0, value}, 8'd13);
  endtask

  task automatic play_round(input logic good);
    logic [2:0] t;
    logic b;
    start_round(good, t);
    for (int i = 2; i >= 0; i--) begin
      b = good ? t[i] : ~t[i];
      press(~b, b);
      if (i > 0) chk("echo", {4'd0, value}, {7'd0, b});
      else begin
        chk("result", {4'd0, value}, good ? 8'd10 : 8'd11);
        exp_streak = good ? ((exp_streak < 9) ? exp_streak + 1 : 9) : 0;
        chk("streak", {4'd0, streak}, 8'(exp_streak));
      end
      release_btn();
    end
    chk("result_hold", {4'd0, value}, good ? 8'd10 : 8'd11);
    @(posedge clk); #1;
    chk("back_idle", {4'd0, value}, 8'd12);
  endtask

  initial begin
    repeat (2) @(posedge clk); #1;
    chk("rst_value", {4'd0, value}, 8'd12);
    chk("rst_streak", {4'd0, streak}, 8'd0);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("idle_value", {4'd0, value}, 8'd12);

    // correct round, streak 0 -> 1
    play_round(1'b1);

    // reset in the middle of SHOW
    press(1'b0, 1'b1);
    chk("mid_show", {7'd0, (value >= 4'd1 && value <= 4'd7)}, 8'd1);
    @(negedge clk); btn_one = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_value", {4'd0, value}, 8'd12);
    chk("rst_mid_streak", {4'd0, streak}, 8'd0);
    exp_streak = 0;
    @(negedge clk); reset = 1'b0;
    repeat (3) @(posedge clk); #1;

    // restart works; then an error clears the streak
    play_round(1'b1);
    play_round(1'b0);

    // timeout after one bit; presses in RESULT ignored
    start_round(1'b0, tgt);
    press(1'b0, 1'b1);
    chk("to_echo", {4'd0, value}, 8'd1);
    release_btn();
    repeat (16) @(posedge clk); #1;
    chk("to_before", {4'd0, value}, 8'd1);
    @(posedge clk); #1;
    chk("to_error", {4'd0, value}, 8'd11);
    chk("to_streak", {4'd0, streak}, 8'd0);
    press(1'b1, 1'b0);
    chk("result_ignore", {4'd0, value}, 8'd11);
    release_btn();
    chk("result_to_idle", {4'd0, value}, 8'd12);

    // both buttons in IDLE: no start
    press(1'b1, 1'b1);
    chk("both_idle", {4'd0, value}, 8'd12);
    release_btn();
    chk("both_idle2", {4'd0, value}, 8'd12);

    // both buttons in BIT1: no bit taken
    start_round(1'b1, tgt);
    press(~tgt[2], tgt[2]);
    chk("b1_echo", {4'd0, value}, {7'd0, tgt[2]});
    release_btn();
    press(1'b1, 1'b1);
    chk("both_bit1", {4'd0, value}, {7'd0, tgt[2]});
    release_btn();
    press(~tgt[1], tgt[1]);
    chk("after_both", {4'd0, value}, {7'd0, tgt[1]});
    release_btn();
    press(~tgt[0], tgt[0]);
    chk("both_result", {4'd0, value}, 8'd10);
    exp_streak = 1;
    chk("both_streak", {4'd0, streak}, 8'd1);
    release_btn();
    @(posedge clk); #1;
    chk("both_idle3", {4'd0, value}, 8'd12);

    // button held ~50 cycles: exactly one bit, timeout runs from that bit
    start_round(1'b0, tgt);
    press(1'b0, 1'b1);
    chk("hold_bit", {4'd0, value}, 8'd1);
    repeat (9) @(posedge clk); #1;
    chk("hold_mid", {4'd0, value}, 8'd1);
    repeat (10) @(posedge clk); #1;
    chk("hold_last", {4'd0, value}, 8'd1);
    @(posedge clk); #1;
    chk("hold_timeout", {4'd0, value}, 8'd11);
    exp_streak = 0;
    chk("hold_streak", {4'd0, streak}, 8'd0);
    repeat (25) @(posedge clk); #1;
    chk("hold_no_start", {4'd0, value}, 8'd12);
    release_btn();
    chk("hold_release", {4'd0, value}, 8'd12);

    // saturation then error
    for (int r = 0; r < 10; r++) play_round(1'b1);
    chk("sat_streak", {4'd0, streak}, 8'd9);
    play_round(1'b0);
    chk("sat_clear", {4'd0, streak}, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
